// File: rtl/ecc_pmul_arbiter.sv
// Round-robin arbiter sharing one double-and-add point-multiplication engine
// between NUM_REQ requesters, with result buffering and a per-job watchdog.
module ecc_pmul_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_BITS = 256,
    parameter int TIMEOUT  = 300000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*MAX_BITS-1:0]   req_px,
    input  logic [NUM_REQ*MAX_BITS-1:0]   req_py,
    input  logic [NUM_REQ*MAX_BITS-1:0]   req_m,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [MAX_BITS-1:0]           rsp_x,
    output logic [MAX_BITS-1:0]           rsp_y,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          eng_valid,
    output logic [MAX_BITS-1:0]           eng_pointx,
    output logic [MAX_BITS-1:0]           eng_pointy,
    output logic [MAX_BITS-1:0]           eng_mul,
    output logic                          eng_abort,
    input  logic                          eng_finished,
    input  logic [MAX_BITS-1:0]           eng_outx,
    input  logic [MAX_BITS-1:0]           eng_outy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RUN,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_last;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     w_winner;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_limit;
    logic                 w_accept;
    logic [NUM_REQ-1:0]   w_owner_oh;
    int                   w_sum;

    assign w_limit    = (r_cnt == CNT_LAST);
    assign w_accept   = req_valid[r_owner];
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    // Scan starts just after the last served requester so a held request waits at most NUM_REQ jobs.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_last;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = int'(r_last) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                w_next = w_accept ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (eng_finished || w_limit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[r_owner]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Dropping eng_valid in the finished cycle guarantees the engine sees a low cycle between jobs.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        eng_valid = 1'b0;
        eng_abort = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_GRANT: req_ready = w_owner_oh & req_valid;
            S_RUN: begin
                eng_valid = !eng_finished && !w_limit;
                eng_abort = !eng_finished && w_limit;
            end
            S_RESP:  rsp_valid = w_owner_oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= '0;
            r_last     <= IDX_LAST;
            r_cnt      <= '0;
            eng_pointx <= '0;
            eng_pointy <= '0;
            eng_mul    <= '0;
            rsp_x      <= '0;
            rsp_y      <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_winner;
                    end
                end
                S_GRANT: begin
                    if (w_accept) begin
                        eng_pointx <= req_px[r_owner*MAX_BITS +: MAX_BITS];
                        eng_pointy <= req_py[r_owner*MAX_BITS +: MAX_BITS];
                        eng_mul    <= req_m[r_owner*MAX_BITS +: MAX_BITS];
                        r_last     <= r_owner;
                        r_cnt      <= '0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (eng_finished) begin
                        rsp_x   <= eng_outx;
                        rsp_y   <= eng_outy;
                        rsp_err <= 1'b0;
                    end else if (w_limit) begin
                        rsp_x   <= '0;
                        rsp_y   <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_pmul_arbiter.sv
// Directed bench for ecc_pmul_arbiter: table of jobs against a behavioural engine,
// plus hand sequences for backpressure and asynchronous reset.
module tb_ecc_pmul_arbiter;

    localparam int NR = 2;
    localparam int MB = 16;
    localparam int TO = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*MB-1:0]  req_px;
    logic [NR*MB-1:0]  req_py;
    logic [NR*MB-1:0]  req_m;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [MB-1:0]     rsp_x;
    logic [MB-1:0]     rsp_y;
    logic              rsp_err;
    logic              busy;
    logic              eng_valid;
    logic [MB-1:0]     eng_pointx;
    logic [MB-1:0]     eng_pointy;
    logic [MB-1:0]     eng_mul;
    logic              eng_abort;
    logic              eng_finished;
    logic [MB-1:0]     eng_outx;
    logic [MB-1:0]     eng_outy;

    ecc_pmul_arbiter #(
        .NUM_REQ (NR),
        .MAX_BITS(MB),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_px      (req_px),
        .req_py      (req_py),
        .req_m       (req_m),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .eng_valid   (eng_valid),
        .eng_pointx  (eng_pointx),
        .eng_pointy  (eng_pointy),
        .eng_mul     (eng_mul),
        .eng_abort   (eng_abort),
        .eng_finished(eng_finished),
        .eng_outx    (eng_outx),
        .eng_outy    (eng_outy)
    );

    always #5 clk = ~clk;

    // Engine model: pulses finished after m_target cycles of eng_valid high (0 = never finishes).
    int m_target;
    int m_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt        <= 0;
            eng_finished <= 1'b0;
        end else if (eng_finished) begin
            eng_finished <= 1'b0;
            m_cnt        <= 0;
        end else if (eng_valid) begin
            m_cnt <= m_cnt + 1;
            if (m_target != 0 && m_cnt + 1 == m_target) eng_finished <= 1'b1;
        end else begin
            m_cnt <= 0;
        end
    end

    int mon_ev = 0;
    int mon_ab = 0;
    int mon_g = 0;
    int mon_multi = 0;
    int grant_log [0:255];
    always @(negedge clk) begin
        if (eng_valid) mon_ev <= mon_ev + 1;
        if (eng_abort) mon_ab <= mon_ab + 1;
        if (|(req_ready & req_valid)) begin
            grant_log[mon_g] <= req_ready[1] ? 1 : 0;
            mon_g <= mon_g + 1;
        end
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) mon_multi <= mon_multi + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic nwait();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  after;
        logic [15:0] px0, py0, m0, px1, py1, m1;
        int          lat;
        logic [15:0] ox, oy;
        int          exp_g;
        logic        exp_err;
    } vec_t;

    task automatic do_job(input vec_t v, input string tag);
        int g0, ev0, ab0, n;
        logic [MB-1:0] ex_px, ex_py, ex_m, ex_x, ex_y;
        int ex_ev;
        ex_px = (v.exp_g == 1) ? v.px1 : v.px0;
        ex_py = (v.exp_g == 1) ? v.py1 : v.py0;
        ex_m  = (v.exp_g == 1) ? v.m1  : v.m0;
        ex_x  = v.exp_err ? 16'h0 : v.ox;
        ex_y  = v.exp_err ? 16'h0 : v.oy;
        ex_ev = (v.lat != 0) ? v.lat : TO - 1;
        req_px    = {v.px1, v.px0};
        req_py    = {v.py1, v.py0};
        req_m     = {v.m1, v.m0};
        eng_outx  = v.ox;
        eng_outy  = v.oy;
        m_target  = v.lat;
        rsp_ready = '0;
        req_valid = v.req;
        g0 = mon_g; ev0 = mon_ev; ab0 = mon_ab;
        n = 0;
        while (mon_g == g0 && n < 10) begin nwait(); n++; end
        check({tag, "_granted"}, 64'(mon_g > g0), 64'd1);
        check({tag, "_grant_idx"}, 64'(grant_log[g0]), 64'(v.exp_g));
        @(posedge clk); #1;
        req_valid = v.after;
        check({tag, "_eng_pointx"}, 64'(eng_pointx), 64'(ex_px));
        check({tag, "_eng_pointy_mul"}, {32'h0, eng_pointy, eng_mul}, {32'h0, ex_py, ex_m});
        n = 0;
        while (rsp_valid == '0 && n < TO + 20) begin nwait(); n++; end
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(2'b01 << v.exp_g));
        check({tag, "_rsp_xy"}, {32'h0, rsp_x, rsp_y}, {32'h0, ex_x, ex_y});
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        check({tag, "_eng_valid_cycles"}, 64'(mon_ev - ev0), 64'(ex_ev));
        check({tag, "_abort_pulses"}, 64'(mon_ab - ab0), 64'(v.exp_err));
        rsp_ready = 2'(2'b01 << v.exp_g);
        @(posedge clk); #1;
        rsp_ready = '0;
        nwait();
        check({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
    endtask

    vec_t vecs [0:7];

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int bad, g0, ev0, n;
        vec_t hv;
        vecs[0] = '{req:2'b01, after:2'b00, px0:16'h5, py0:16'h1, m0:16'h2, px1:16'h0, py1:16'h0, m1:16'h0,
                    lat:10, ox:16'h6, oy:16'h3, exp_g:0, exp_err:1'b0};
        vecs[1] = '{req:2'b11, after:2'b11, px0:16'h10, py0:16'h11, m0:16'h12, px1:16'h20, py1:16'h21, m1:16'h22,
                    lat:3, ox:16'h101, oy:16'h102, exp_g:1, exp_err:1'b0};
        vecs[2] = '{req:2'b11, after:2'b11, px0:16'h30, py0:16'h31, m0:16'h32, px1:16'h40, py1:16'h41, m1:16'h42,
                    lat:4, ox:16'h201, oy:16'h202, exp_g:0, exp_err:1'b0};
        vecs[3] = '{req:2'b11, after:2'b11, px0:16'h50, py0:16'h51, m0:16'h52, px1:16'h60, py1:16'h61, m1:16'h62,
                    lat:2, ox:16'h301, oy:16'h302, exp_g:1, exp_err:1'b0};
        vecs[4] = '{req:2'b11, after:2'b00, px0:16'h70, py0:16'h71, m0:16'h72, px1:16'h80, py1:16'h81, m1:16'h82,
                    lat:5, ox:16'h401, oy:16'h402, exp_g:0, exp_err:1'b0};
        vecs[5] = '{req:2'b10, after:2'b00, px0:16'h0, py0:16'h0, m0:16'h0, px1:16'h9A, py1:16'h9B, m1:16'h9C,
                    lat:0, ox:16'hAAAA, oy:16'h5555, exp_g:1, exp_err:1'b1};
        vecs[6] = '{req:2'b01, after:2'b00, px0:16'hA1, py0:16'hA2, m0:16'hA3, px1:16'h0, py1:16'h0, m1:16'h0,
                    lat:4, ox:16'h1234, oy:16'h5678, exp_g:0, exp_err:1'b0};
        vecs[7] = '{req:2'b10, after:2'b00, px0:16'h0, py0:16'h0, m0:16'h0, px1:16'hB1, py1:16'hB2, m1:16'hB3,
                    lat:TO - 1, ox:16'hBEEF, oy:16'hCAFE, exp_g:1, exp_err:1'b0};

        rst = 1'b0; req_valid = '0; rsp_ready = '0; req_px = '0; req_py = '0; req_m = '0;
        eng_outx = '0; eng_outy = '0; m_target = 0;
        repeat (3) nwait();
        check("reset_outputs_zero", 64'(|{req_ready, rsp_valid, rsp_x, rsp_y, rsp_err, busy, eng_valid,
                                          eng_pointx, eng_pointy, eng_mul, eng_abort}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        nwait();

        for (int i = 0; i < 8; i++) do_job(vecs[i], $sformatf("job%0d", i));

        // Backpressure: result held while requester 1 waits and the other rsp_ready bit toggles
        hv = '{req:2'b01, after:2'b00, px0:16'hC1, py0:16'hC2, m0:16'hC3, px1:16'hD1, py1:16'hD2, m1:16'hD3,
               lat:5, ox:16'h0F0F, oy:16'h7070, exp_g:0, exp_err:1'b0};
        req_px = {hv.px1, hv.px0}; req_py = {hv.py1, hv.py0}; req_m = {hv.m1, hv.m0};
        eng_outx = hv.ox; eng_outy = hv.oy; m_target = hv.lat; req_valid = 2'b01;
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            nwait(); n++;
            if (busy && !eng_valid && rsp_valid == '0 && req_ready == '0 && req_valid == 2'b01) req_valid = 2'b00;
        end
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        g0 = mon_g; ev0 = mon_ev; bad = 0;
        for (int i = 0; i < 20; i++) begin
            nwait();
            if (rsp_valid != 2'b01 || rsp_x != 16'h0F0F || rsp_y != 16'h7070 || rsp_err || !busy) bad++;
        end
        check("bp_rsp_stable_cycles_bad", 64'(bad), 64'd0);
        check("bp_no_new_grant", 64'(mon_g - g0), 64'd0);
        check("bp_eng_valid_low", 64'(mon_ev - ev0), 64'd0);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = '0;
        hv.req = 2'b10; hv.exp_g = 1; hv.lat = 3; hv.ox = 16'h1111; hv.oy = 16'h2222;
        do_job(hv, "bp_next");

        // Asynchronous reset in the middle of a job that never finishes
        req_px = {16'hE1, 16'hE0}; req_py = {16'hE3, 16'hE2}; req_m = {16'hE5, 16'hE4};
        m_target = 0; req_valid = 2'b01;
        n = 0;
        while (!eng_valid && n < 10) begin nwait(); n++; end
        req_valid = 2'b00;
        nwait(); nwait();
        check("rst_run_before", 64'(eng_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_async_outputs_zero", 64'(|{req_ready, rsp_valid, rsp_x, rsp_y, rsp_err, busy, eng_valid,
                                              eng_pointx, eng_pointy, eng_mul, eng_abort}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        hv = '{req:2'b10, after:2'b00, px0:16'h0, py0:16'h0, m0:16'h0, px1:16'hF1, py1:16'hF2, m1:16'hF3,
               lat:2, ox:16'h3333, oy:16'h4444, exp_g:1, exp_err:1'b0};
        do_job(hv, "post_rst_r1");
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        hv = '{req:2'b11, after:2'b00, px0:16'h71, py0:16'h72, m0:16'h73, px1:16'h81, py1:16'h82, m1:16'h83,
               lat:2, ox:16'h5555, oy:16'h6666, exp_g:0, exp_err:1'b0};
        do_job(hv, "post_rst_both");

        check("never_two_onehot_violations", 64'(mon_multi), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ecc_pmul_arbiter.md
Name: ecc_pmul_arbiter

Overview:
- Shares one scalar point-multiplication engine (double-and-add core) between NUM_REQ independent requesters, e.g. the mP path and the mnP path of the ECC top level.
- Round-robin arbitrates jobs and latches the winner's operands.
- Drives the engine's level-held valid until its finished pulse, buffers the result and returns it by valid/ready handshake.
- Includes a watchdog that aborts hung jobs.
- Curve coefficients a, b, prime and mode are wired to the engine directly by the parent and are outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BITS, 256, operand/result width.
- TIMEOUT, 300000, engine cycles allowed per job before abort (>= 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  job request per requester; held until accepted
- req_ready  out  NUM_REQ  one-hot accept pulse; a job transfers when req_valid[i] & req_ready[i]
- req_px  in  NUM_REQ*MAX_BITS  point x, requester i in slice i
- req_py  in  NUM_REQ*MAX_BITS  point y
- req_m  in  NUM_REQ*MAX_BITS  scalar
- rsp_valid  out  NUM_REQ  one-hot result-valid to the owning requester
- rsp_ready  in  NUM_REQ  result accept
- rsp_x  out  MAX_BITS  result x
- rsp_y  out  MAX_BITS  result y
- rsp_err  out  1  result is a timeout abort
- busy  out  1  state != IDLE
- eng_valid  out  1  engine start/hold, level
- eng_pointx  out  MAX_BITS  latched point x
- eng_pointy  out  MAX_BITS  latched point y
- eng_mul  out  MAX_BITS  latched scalar
- eng_abort  out  1  one-cycle pulse on timeout
- eng_finished  in  1  engine done pulse; eng_outx/eng_outy valid this cycle
- eng_outx  in  MAX_BITS  engine result x
- eng_outy  in  MAX_BITS  engine result y

Behaviour:
- Reset values (async, rst low):
  - State IDLE.
  - All outputs 0: req_ready, rsp_valid, rsp_x, rsp_y, rsp_err, busy, eng_valid, eng_point*, eng_mul, eng_abort.
  - Grant pointer last = NUM_REQ-1, so requester 0 has first priority.
  - Owner register and watchdog counter 0.
- States: IDLE -> GRANT -> RUN -> RESP -> IDLE.
- IDLE:
  - If any req_valid, choose winner g = first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Register owner = g; go to GRANT.
- GRANT (1 cycle):
  - req_ready[g] = 1.
  - Latch slice g of req_px/py/m into eng_pointx/eng_pointy/eng_mul.
  - last <= g; counter <= 0; go to RUN.
  - The requester must still hold req_valid here; if req_valid[g] has dropped, nothing is latched and the block returns to IDLE. This is a protocol violation but must be handled.
- RUN:
  - eng_valid = 1 except in the eng_finished cycle, where it is driven 0 combinationally. This guarantees at least one low cycle between jobs.
  - Counter increments every RUN cycle.
  - On eng_finished: rsp_x/rsp_y <= eng_outx/eng_outy, rsp_err <= 0, go to RESP.
  - Else if counter == TIMEOUT-1: eng_abort pulse, eng_valid 0, rsp_x/rsp_y <= 0, rsp_err <= 1, go to RESP.
  - eng_finished in the same cycle as the timeout: finished wins, no abort.
- RESP:
  - rsp_valid[owner] = 1 and rsp_x/rsp_y/rsp_err stable until rsp_ready[owner].
  - Then rsp_valid drops next cycle and the state returns to IDLE.
  - rsp_ready on other bits is ignored.
  - eng_finished arriving in IDLE, GRANT or RESP is ignored.
- Latency: request asserted in IDLE to eng_valid high = 2 cycles. Back-to-back jobs have at least 2 idle engine cycles between them (RESP handshake, IDLE).
- Fairness: a requester that keeps req_valid high is served within NUM_REQ jobs.
- Operand registers hold their last values outside RUN; they are not cleared.
- Reset mid-RUN: eng_valid drops immediately (async) and the pending job is lost. The requester must reissue it.

Test Plan:
- Single job: req_valid=01, px=5, py=1, m=2; engine model finishes after 10 cycles with (6,3) -> req_ready[0] pulses once; eng_valid high exactly 10 cycles with low in the finished cycle; rsp_valid=01 with rsp_x=6, rsp_y=3, rsp_err=0; consumed on rsp_ready=01.
- Contention: req_valid=11 held through 4 jobs -> grant order 0,1,0,1; rsp_valid one-hot matches owner; never two requesters granted together.
- Backpressure: rsp_ready held 0 for 20 cycles after finish -> rsp_valid and data stable; no new req_ready pulse; eng_valid 0 throughout.
- Timeout: TIMEOUT=8, engine never finishes -> eng_abort single pulse on the 8th RUN cycle; rsp_err=1, rsp_x=rsp_y=0; next job proceeds normally.
- Tie: eng_finished on the same cycle as the timeout limit -> no eng_abort; rsp_err=0 with the engine data.
- Reset: rst low for 1 cycle mid-RUN -> all outputs 0 asynchronously; after release, req_valid=10 is granted to requester 1 first if requester 0 is idle, and requester 0 has priority if both are set.
